// File: rtl/conv2d_out_writer.sv
// Output writer for the conv2d engine: ReLU/shift/saturate, small FIFO, SRAM drain, frame tracking.
// Optional ReLU before the shift is enabled by defining CONV_OUT_RELU_EN.
module conv2d_out_writer #(
    parameter int IN_W        = 16,
    parameter int OUT_W       = 8,
    parameter int SHIFT       = 4,
    parameter int AW          = 16,
    parameter int DEPTH       = 8,
    parameter int FRAME_WORDS = 1024
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       clear_i,
    input  logic                       wen_i,
    input  logic [AW-1:0]              waddr_i,
    input  logic [IN_W-1:0]            data_i,
    output logic                       mem_wen_o,
    output logic [AW-1:0]              mem_addr_o,
    output logic [OUT_W-1:0]           mem_data_o,
    input  logic                       mem_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       overflow_o,
    output logic                       done_o
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = LW - 1;
    localparam int CW = $clog2(FRAME_WORDS + 1);

    localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] SAT_MIN = IN_W'(-(1 << (OUT_W - 1)));

    logic signed [IN_W-1:0] x_c, y_c;
    logic [OUT_W-1:0]       sat_c;

    always_comb begin
        x_c = $signed(data_i);
`ifdef CONV_OUT_RELU_EN
        if (x_c[IN_W-1]) x_c = '0;
`else
        x_c = $signed(data_i);
`endif
        y_c = x_c >>> SHIFT;
        if (y_c > SAT_MAX)      sat_c = SAT_MAX[OUT_W-1:0];
        else if (y_c < SAT_MIN) sat_c = SAT_MIN[OUT_W-1:0];
        else                    sat_c = y_c[OUT_W-1:0];
    end

    logic             s1_vld_q;
    logic [AW-1:0]    s1_addr_q;
    logic [OUT_W-1:0] s1_data_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_data_q <= '0;
        end else begin
            s1_vld_q  <= wen_i & ~clear_i;
            s1_addr_q <= waddr_i;
            s1_data_q <= sat_c;
        end
    end

    logic [AW-1:0]    addr_mem_q [DEPTH];
    logic [OUT_W-1:0] data_mem_q [DEPTH];
    logic [LW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d, done_q, done_d;
    logic             empty, full, push, pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[IW] != rptr_q[IW]) && (wptr_q[IW-1:0] == rptr_q[IW-1:0]);
    assign pop   = ~empty & mem_ready_i & ~clear_i;
    assign push  = s1_vld_q & (~full | pop) & ~clear_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        done_d = 1'b0;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end else begin
            if (push) wptr_d = wptr_q + LW'(1);
            if (pop) begin
                rptr_d = rptr_q + LW'(1);
                if (cnt_q == CW'(FRAME_WORDS - 1)) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            if (s1_vld_q && !push) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
        end
    end

    // Storage is not reset; outputs are masked while the FIFO is empty instead.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem_q[wptr_q[IW-1:0]] <= s1_addr_q;
            data_mem_q[wptr_q[IW-1:0]] <= s1_data_q;
        end
    end

    assign mem_wen_o  = ~empty;
    assign mem_addr_o = empty ? '0 : addr_mem_q[rptr_q[IW-1:0]];
    assign mem_data_o = empty ? '0 : data_mem_q[rptr_q[IW-1:0]];
    assign level_o    = wptr_q - rptr_q;
    assign overflow_o = ovf_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_conv2d_out_writer.sv
// Directed bench for conv2d_out_writer: transform vectors, overflow, full-throughput, frames, async reset.
module tb_conv2d_out_writer;
    localparam int FW = 1024;
`ifdef CONV_OUT_RELU_EN
    localparam logic RELU = 1'b1;
`else
    localparam logic RELU = 1'b0;
`endif

    logic        clk_i = 1'b0, rstn_i = 1'b0, clear_i = 1'b0, wen_i = 1'b0, mem_ready_i = 1'b0;
    logic [15:0] waddr_i = '0, data_i = '0;
    logic        mem_wen_o, overflow_o, done_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_data_o;
    logic [3:0]  level_o;

    conv2d_out_writer dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .clear_i(clear_i), .wen_i(wen_i),
        .waddr_i(waddr_i), .data_i(data_i), .mem_wen_o(mem_wen_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i),
        .level_o(level_o), .overflow_o(overflow_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0, bad = 0;

    typedef struct {
        logic [15:0] data;
        logic [15:0] addr;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    // Random-stall producer/consumer; producer throttles on level so nothing is dropped.
    task automatic run_frames(input int nfr, input logic [15:0] base);
        int   sent, pops, cyc, dones;
        logic popped;
        sent = 0; pops = 0; cyc = 0; dones = 0;
        while (pops < nfr * FW && cyc < 20000) begin
            mem_ready_i = ($urandom_range(0, 3) != 0);
            wen_i = (sent < nfr * FW) && (level_o <= 4'd5);
            if (wen_i) begin
                waddr_i = base + 16'(sent);
                data_i  = 16'(sent);
                sent++;
            end
            popped = mem_wen_o && mem_ready_i;
            if (popped) begin
                chk("frame_addr", 32'(mem_addr_o), 32'(base + 16'(pops)));
                pops++;
            end
            tick();
            cyc++;
            chk("frame_done", 32'(done_o), 32'(popped && (pops % FW == 0)));
            if (done_o) dones++;
        end
        wen_i = 1'b0;
        chk("frame_pops", 32'(pops), 32'(nfr * FW));
        chk("frame_pulses", 32'(dones), 32'(nfr));
        chk("frame_ovf", 32'(overflow_o), 32'h0);
    endtask

    initial begin
        vecs[0]  = '{16'h0123, 16'h0005, 8'h12};
        vecs[1]  = '{16'h7FFF, 16'h0006, 8'h7F};
        vecs[2]  = '{16'hFF00, 16'h0007, RELU ? 8'h00 : 8'hF0};
        vecs[3]  = '{16'h8000, 16'h0008, RELU ? 8'h00 : 8'h80};
        vecs[4]  = '{16'h0000, 16'h0009, 8'h00};
        vecs[5]  = '{16'h07F0, 16'h000A, 8'h7F};
        vecs[6]  = '{16'h0800, 16'h000B, 8'h7F};
        vecs[7]  = '{16'hF800, 16'h000C, RELU ? 8'h00 : 8'h80};
        vecs[8]  = '{16'hF7F0, 16'h000D, RELU ? 8'h00 : 8'h80};
        vecs[9]  = '{16'hFFFF, 16'h000E, RELU ? 8'h00 : 8'hFF};
        vecs[10] = '{16'h000F, 16'hBEEF, 8'h00};

        #3;
        chk("rst_wen", 32'(mem_wen_o), 32'h0);
        chk("rst_addr", 32'(mem_addr_o), 32'h0);
        chk("rst_data", 32'(mem_data_o), 32'h0);
        chk("rst_level", 32'(level_o), 32'h0);
        chk("rst_ovf", 32'(overflow_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        #10 rstn_i = 1'b1;
        tick();

        // Single-word transform vectors: visible two edges after sampling, popped on the third.
        mem_ready_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            wen_i = 1'b1; waddr_i = vecs[i].addr; data_i = vecs[i].data;
            tick();
            wen_i = 1'b0;
            chk("vec_early_wen", 32'(mem_wen_o), 32'h0);
            tick();
            chk("vec_wen", 32'(mem_wen_o), 32'h1);
            chk("vec_addr", 32'(mem_addr_o), 32'(vecs[i].addr));
            chk("vec_data", 32'(mem_data_o), 32'(vecs[i].exp));
            chk("vec_level1", 32'(level_o), 32'h1);
            tick();
            chk("vec_wen_after", 32'(mem_wen_o), 32'h0);
            chk("vec_level0", 32'(level_o), 32'h0);
        end

        // Overflow: 10 writes into a stalled FIFO keep the first 8.
        mem_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wen_i = 1'b1; waddr_i = 16'h0100 + 16'(i); data_i = 16'(i << 4);
            tick();
        end
        wen_i = 1'b0;
        tick();
        chk("ovf_level", 32'(level_o), 32'h8);
        chk("ovf_flag", 32'(overflow_o), 32'h1);
        mem_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain_wen", 32'(mem_wen_o), 32'h1);
            chk("ovf_drain_addr", 32'(mem_addr_o), 32'(16'h0100 + 16'(i)));
            chk("ovf_drain_data", 32'(mem_data_o), 32'(i));
            tick();
        end
        chk("ovf_empty", 32'(mem_wen_o), 32'h0);
        chk("ovf_sticky", 32'(overflow_o), 32'h1);
        do_clear();
        chk("clr_ovf", 32'(overflow_o), 32'h0);
        chk("clr_level", 32'(level_o), 32'h0);
        chk("clr_wen", 32'(mem_wen_o), 32'h0);

        // Full FIFO with simultaneous push/pop every cycle.
        mem_ready_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            wen_i = 1'b1; waddr_i = 16'h0200 + 16'(k); data_i = 16'h0010;
            tick();
        end
        chk("full_level", 32'(level_o), 32'h8);
        mem_ready_i = 1'b1;
        for (int j = 0; j < 100; j++) begin
            waddr_i = 16'h0200 + 16'(9 + j);
            chk("full_addr", 32'(mem_addr_o), 32'(16'h0200 + 16'(j)));
            tick();
            chk("full_steady_level", 32'(level_o), 32'h8);
        end
        chk("full_no_ovf", 32'(overflow_o), 32'h0);
        wen_i = 1'b0;
        repeat (12) tick();
        chk("full_drained", 32'(level_o), 32'h0);

        // Two frames with random stalls.
        do_clear();
        run_frames(2, 16'h1000);

        // Async reset mid-frame with 5 buffered entries.
        do_clear();
        mem_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wen_i = 1'b1; waddr_i = 16'h2000 + 16'(i); data_i = 16'h0100;
            tick();
        end
        wen_i = 1'b0;
        repeat (4) tick();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wen_i = 1'b1; waddr_i = 16'h2100 + 16'(i); data_i = 16'h0100;
            tick();
        end
        wen_i = 1'b0;
        tick();
        chk("pre_rst_level", 32'(level_o), 32'h5);
        #2 rstn_i = 1'b0;
        #1;
        chk("arst_wen", 32'(mem_wen_o), 32'h0);
        chk("arst_addr", 32'(mem_addr_o), 32'h0);
        chk("arst_data", 32'(mem_data_o), 32'h0);
        chk("arst_level", 32'(level_o), 32'h0);
        chk("arst_ovf", 32'(overflow_o), 32'h0);
        chk("arst_done", 32'(done_o), 32'h0);
        #1 rstn_i = 1'b1;
        tick();
        chk("post_rst_wen", 32'(mem_wen_o), 32'h0);
        run_frames(1, 16'h3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv2d_out_writer.md
# conv2d_out_writer

Downstream sink for the 2D convolution engine. Captures its per-cycle result stream (write enable, write address, 16-bit signed sum) and applies optional ReLU, an arithmetic right shift and signed saturation to the output width. Buffers results in a small FIFO and drains them to the output feature SRAM write port under a ready handshake. Reports FIFO level, a sticky overflow flag and an end-of-frame pulse.

## Interface
- IN_W, 16, input sample width (signed two's complement)
- OUT_W, 8, output word width (signed); 2 ≤ OUT_W ≤ IN_W
- SHIFT, 4, arithmetic right-shift amount applied before saturation; 0 ≤ SHIFT < IN_W
- AW, 16, address width
- DEPTH, 8, FIFO entries; power of two, ≥ 2
- FRAME_WORDS, 1024, words drained per frame (32×32)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous flush of all state
- wen_i  in  1  input sample valid (engine write enable)
- waddr_i  in  AW  input sample address
- data_i  in  IN_W  input sample (signed)
- mem_wen_o  out  1  SRAM write request
- mem_addr_o  out  AW  SRAM write address
- mem_data_o  out  OUT_W  SRAM write data
- mem_ready_i  in  1  SRAM accepts the write this cycle
- level_o  out  $clog2(DEPTH+1)  FIFO occupancy
- overflow_o  out  1  sticky: a sample was dropped
- done_o  out  1  one-cycle pulse at end of frame

## Operation
- Stage 1 (input register): on every cycle, latch wen_i, waddr_i and the transformed data_i. The valid bit is cleared on clear_i.
- Transform, combinational before the stage 1 register:
  - x = signed(data_i).
  - If ReLU is enabled and x < 0, then x = 0.
  - y = x >>> SHIFT (arithmetic shift).
  - Saturate y to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- Stage 2 (FIFO):
  - A valid stage 1 entry is pushed if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and overflow_o is set. overflow_o stays set until clear_i or reset.
- Drain:
  - mem_wen_o = FIFO not empty. mem_addr_o and mem_data_o show the FIFO head.
  - Pop when mem_wen_o && mem_ready_i.
  - Outputs hold stable while mem_wen_o is high and mem_ready_i is low.
- Frame counter:
  - Increments on each pop.
  - On the pop that brings the count to FRAME_WORDS, done_o pulses high the following cycle and the counter returns to 0.
- level_o counts entries in the FIFO only; the stage 1 entry is excluded.
- Read and write pointers wrap modulo DEPTH. An extra pointer bit distinguishes full from empty.
- clear_i has priority over push and pop in the same cycle. It empties the FIFO and zeroes the counter, overflow_o and the stage 1 valid bit. No write is issued in the clear cycle's successor unless new data arrives.

## Timing
- Reset values: mem_wen_o=0, mem_addr_o=0, mem_data_o=0, level_o=0, overflow_o=0, done_o=0. Pointers, counter and stage 1 valid are all 0.
- Latency: wen_i sampled at edge N leads to the FIFO write at edge N+1, so mem_wen_o is high after edge N+1 (2 edges, into an empty FIFO).
- Throughput: one word per cycle while mem_ready_i is held high.
- A push to a full FIFO that coincides with a pop is accepted. level_o is unchanged.
- A push and a pop on an empty FIFO: the pop is not possible (mem_wen_o=0). The push is accepted and level_o becomes 1.
- done_o is registered. It asserts for exactly one cycle, one edge after the terminal pop.
- Asynchronous reset mid-frame discards all buffered data and the frame count immediately. Outputs go to their reset values without waiting for a clock edge.

## Configuration
- `CONV_OUT_RELU_EN` defined: negative samples are forced to 0 before the shift, so mem_data_o is never negative.
- Undefined: no ReLU. Negative samples are shifted and saturated symmetrically.

## Test plan
- Defaults, mem_ready_i=1, single wen_i with data_i=0x0123 and waddr_i=0x0005 → two edges later mem_wen_o=1, mem_addr_o=0x0005, mem_data_o=0x12. It is popped next cycle and level_o returns to 0.
- data_i=0x7FFF → mem_data_o=0x7F (saturated). data_i=0xFF00 → mem_data_o=0x00 with CONV_OUT_RELU_EN, and 0xF0 (−16) without it. With CONV_OUT_RELU_EN undefined, data_i=0x8000 → 0x80.
- mem_ready_i=0, 10 consecutive writes → level_o saturates at 8, overflow_o=1, and the first 8 addresses are retained. Raise mem_ready_i → 8 writes drain in order. overflow_o stays 1 until clear_i.
- FIFO full with mem_ready_i=1 and continuous wen_i → no drops over 100 cycles, overflow_o stays 0, level_o is constant.
- 1024 writes with random mem_ready_i stalls → all 1024 addresses are written in order, done_o pulses exactly once (the cycle after the 1024th pop), and the counter restarts for a second frame.
- Assert rstn_i low mid-frame with the FIFO holding 5 entries → all outputs go to 0 immediately. After release, the next frame's done_o requires a full 1024 pops.
